// File: rtl/sr_bank_arb.sv
// Round-robin arbiter in front of a shared bank of SR flags.
// The winner of each cycle sets, clears or holds one flag; s=r=1 is flagged as an error.
module sr_flag_cell (
    input  logic clk,
    input  logic reset,
    input  logic sel,
    input  logic s,
    input  logic r,
    output logic q
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (sel) begin
            case ({s, r})
                2'b10:   q_d = 1'b1;
                2'b01:   q_d = 1'b0;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= 1'b0;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

module sr_bank_arb #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      s,
    input  logic [NREQ-1:0]      r,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAG-1:0]     q,
    output logic                 err,
    output logic [7:0]           err_cnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_d, ptr_q;
    logic [NREQ-1:0] gnt_d, gnt_q;
    logic            err_d, err_q;
    logic [7:0]      err_cnt_d, err_cnt_q;

    logic            found;
    logic [PW-1:0]   win;
    logic [IDXW-1:0] win_idx;
    logic            win_s, win_r;

    // Scan from ptr upward, wrapping; the first requester seen wins.
    always_comb begin : arb_comb
        int cand;
        cand  = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = PW'(cand);
            end
        end
    end

    assign win_idx = idx[int'(win)*IDXW +: IDXW];
    assign win_s   = found & s[win];
    assign win_r   = found & r[win];

    always_comb begin
        gnt_d     = '0;
        ptr_d     = ptr_q;
        err_d     = win_s & win_r;
        err_cnt_d = err_cnt_q;
        if (found) begin
            gnt_d[win] = 1'b1;
            ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            gnt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Indices at or beyond NFLAG select no cell and therefore change nothing.
    for (genvar f = 0; f < NFLAG; f++) begin : g_flag
        sr_flag_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .sel   (found && (win_idx == IDXW'(f))),
            .s     (win_s),
            .r     (win_r),
            .q     (q[f])
        );
    end

    assign gnt     = gnt_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_sr_bank_arb.sv
// Scoreboard bench for sr_bank_arb: a behavioural model predicts every cycle,
// directed tasks add fixed expectations for the key scenarios.
module tb_sr_bank_arb;
    logic        clk;
    logic        reset;
    logic [3:0]  req, s, r;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        err;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   m_ptr, m_cnt;
    logic [7:0] m_q;
    int   checks, errors;

    sr_bank_arb #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .s       (s),
        .r       (r),
        .idx     (idx),
        .gnt     (gnt),
        .q       (q),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_rq(input int i, input bit sv, input bit rv, input int ix);
        logic [2:0] ixv;
        ixv = ix[2:0];
        s[i] = sv;
        r[i] = rv;
        idx[i*3 +: 3] = ixv;
    endtask

    task automatic clear_cmds();
        req = '0; s = '0; r = '0; idx = '0;
    endtask

    // Predict the result of the coming edge, push it, clock, then pop and compare.
    task automatic step();
        exp_t e;
        bit   fnd;
        int   w, c;
        logic [2:0] ix;
        e.gnt = '0; e.err = 1'b0;
        if (reset) begin
            m_q = '0; m_cnt = 0; m_ptr = 0;
        end else begin
            fnd = 0; w = 0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!fnd && req[c]) begin fnd = 1; w = c; end
            end
            if (fnd) begin
                e.gnt[w] = 1'b1;
                ix = idx[w*3 +: 3];
                if (s[w] && !r[w])      m_q[ix] = 1'b1;
                else if (!s[w] && r[w]) m_q[ix] = 1'b0;
                else if (s[w] && r[w]) begin
                    e.err = 1'b1;
                    if (m_cnt != 255) m_cnt++;
                end
                m_ptr = (w + 1) % 4;
            end
        end
        e.q = m_q;
        e.cnt = m_cnt[7:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt) begin errors++; $display("FAIL sb_gnt: got %b expected %b", gnt, e.gnt); end
        checks++;
        if (q !== e.q) begin errors++; $display("FAIL sb_q: got %h expected %h", q, e.q); end
        checks++;
        if (err !== e.err) begin errors++; $display("FAIL sb_err: got %b expected %b", err, e.err); end
        checks++;
        if (err_cnt !== e.cnt) begin errors++; $display("FAIL sb_err_cnt: got %0d expected %0d", err_cnt, e.cnt); end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; s = 4'b1111; r = '0; idx = 12'hFFF;
        step();
        step();
        checks++;
        if (gnt !== 4'b0000 || q !== 8'h00 || err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b q=%h err=%b cnt=%0d expected all zero", gnt, q, err, err_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_op();
        clear_cmds();
        req = 4'b0001; set_rq(0, 1, 0, 5);
        step();
        checks++;
        if (gnt !== 4'b0001 || q !== 8'h20) begin
            errors++; $display("FAIL single_op: got gnt=%b q=%h expected 0001/20", gnt, q);
        end
        // ptr is now 1, so an all-request cycle must go to requester 1
        clear_cmds();
        req = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL ptr_after_single: got %b expected 0010", gnt); end
    endtask

    task automatic test_clear_hold();
        clear_cmds();
        req = 4'b0001; set_rq(0, 0, 1, 5);
        step();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL clear: got q=%h expected 00", q); end
        set_rq(0, 0, 0, 5);
        step();
        checks++;
        if (gnt !== 4'b0001 || q !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL hold: got gnt=%b q=%h err=%b expected 0001/00/0", gnt, q, err);
        end
        clear_cmds();
        step();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
    endtask

    task automatic test_round_robin();
        reset = 1'b1; clear_cmds(); step(); reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] expg;
            expg = 4'b0001 << (k % 4);
            step();
            checks++;
            if (gnt !== expg) begin errors++; $display("FAIL round_robin[%0d]: got %b expected %b", k, gnt, expg); end
        end
    endtask

    task automatic test_collision();
        reset = 1'b1; clear_cmds(); step(); reset = 1'b0;
        req = 4'b0110; set_rq(1, 1, 0, 2); set_rq(2, 0, 1, 2);
        step();
        checks++;
        if (gnt !== 4'b0010 || q[2] !== 1'b1) begin
            errors++; $display("FAIL collision_first: got gnt=%b q2=%b expected 0010/1", gnt, q[2]);
        end
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || q[2] !== 1'b0) begin
            errors++; $display("FAIL collision_second: got gnt=%b q2=%b expected 0100/0", gnt, q[2]);
        end
        clear_cmds();
    endtask

    task automatic test_illegal_sat();
        reset = 1'b1; clear_cmds(); step(); reset = 1'b0;
        req = 4'b0001; set_rq(0, 1, 1, 3);
        step();
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || q !== 8'h00) begin
            errors++; $display("FAIL illegal: got err=%b cnt=%0d q=%h expected 1/1/00", err, err_cnt, q);
        end
        // illegal command from a requester that loses arbitration is ignored
        req = 4'b0011; set_rq(0, 1, 0, 4); set_rq(1, 1, 1, 4);
        m_ptr = m_ptr; // ptr is 1 here, so requester 1 wins; drop it to let 0 win
        req = 4'b0001;
        step();
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd1 || q !== 8'h10) begin
            errors++; $display("FAIL err_clear: got err=%b cnt=%0d q=%h expected 0/1/10", err, err_cnt, q);
        end
        req = 4'b0001; set_rq(0, 1, 1, 3);
        for (int k = 0; k < 260; k++) step();
        checks++;
        if (err_cnt !== 8'd255 || err !== 1'b1) begin
            errors++; $display("FAIL saturation: got cnt=%0d err=%b expected 255/1", err_cnt, err);
        end
        clear_cmds();
    endtask

    task automatic test_midstream_reset();
        bit seen;
        reset = 1'b1; clear_cmds(); step(); reset = 1'b0;
        req = 4'b1111; set_rq(0, 1, 0, 1); set_rq(3, 1, 1, 0);
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            if (gnt === 4'b0100) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midstream_wait: got no 0100 grant expected one within 8 cycles"); end
        reset = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0000 || q !== 8'h00 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL midstream_reset: got gnt=%b q=%h cnt=%0d expected 0000/00/0", gnt, q, err_cnt);
        end
        reset = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL post_reset_gnt: got %b expected 0001", gnt); end
        clear_cmds();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            reset = ($urandom_range(0, 39) == 0);
            req = 4'($urandom_range(0, 15));
            s   = 4'($urandom_range(0, 15));
            r   = 4'($urandom_range(0, 15));
            idx = 12'($urandom_range(0, 4095));
            step();
        end
        reset = 1'b0;
        clear_cmds();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_ptr = 0; m_cnt = 0; m_q = '0;
        reset = 1'b1;
        clear_cmds();
        test_reset();
        test_single_op();
        test_clear_hold();
        test_round_robin();
        test_collision();
        test_illegal_sat();
        test_midstream_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
